// File: rtl/vend_fsm_param.sv
// Parametrised coin-accumulating vending controller: credits coins, dispenses at PRICE,
// returns change, refunds on cancel and flags coins strobed while busy.
module vend_fsm_param #(
  parameter int AMT_W = 5,
  parameter int PRICE = 20,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AMT_W-1:0] amt,
  input  logic             amt_vld,
  input  logic             cancel,
  output logic             coffee,
  output logic [AMT_W:0]   change,
  output logic             change_vld,
  output logic             reject,
  output logic [AMT_W:0]   credit,
  output logic [CNT_W-1:0] count
);

  localparam logic [AMT_W:0]   PRICE_V = (AMT_W+1)'(PRICE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [AMT_W:0]   r_credit;
  logic [AMT_W:0]   w_credit_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_coffee;
  logic             w_coffee_next;
  logic [AMT_W:0]   r_change;
  logic [AMT_W:0]   w_change_next;
  logic             r_change_vld;
  logic             w_change_vld_next;
  logic             r_reject;
  logic             w_reject_next;

  logic             w_coin;
  logic [AMT_W:0]   w_coin_amt;
  logic [AMT_W:0]   w_sum;
  logic             w_sale;
  logic [CNT_W-1:0] w_count_inc;

  // A zero-valued strobe is treated as no coin at all.
  assign w_coin      = amt_vld && (amt != '0);
  assign w_coin_amt  = w_coin ? {1'b0, amt} : '0;
  assign w_sum       = r_credit + w_coin_amt;
  assign w_sale      = w_coin && (w_sum >= PRICE_V);
  assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;

  always_comb begin
    w_state_next      = r_state;
    w_credit_next     = r_credit;
    w_count_next      = r_count;
    w_coffee_next     = 1'b0;
    w_change_next     = '0;
    w_change_vld_next = 1'b0;
    w_reject_next     = 1'b0;

    case (r_state)
      IDLE, COLLECT: begin
        // Cancel wins over a coin that would otherwise complete the sale.
        if ((r_state == COLLECT) && cancel) begin
          w_state_next      = REFUND;
          w_change_next     = w_sum;
          w_change_vld_next = 1'b1;
          w_credit_next     = '0;
        end else if (w_sale) begin
          w_state_next      = DISPENSE;
          w_coffee_next     = 1'b1;
          w_change_next     = w_sum - PRICE_V;
          w_change_vld_next = (w_sum != PRICE_V);
          w_credit_next     = '0;
          w_count_next      = w_count_inc;
        end else if (w_coin) begin
          w_state_next  = COLLECT;
          w_credit_next = w_sum;
        end
      end

      DISPENSE, REFUND: begin
        w_state_next  = IDLE;
        w_credit_next = '0;
        w_reject_next = w_coin;
      end

      default: begin
        w_state_next  = IDLE;
        w_credit_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_credit     <= '0;
      r_count      <= '0;
      r_coffee     <= 1'b0;
      r_change     <= '0;
      r_change_vld <= 1'b0;
      r_reject     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_credit     <= w_credit_next;
      r_count      <= w_count_next;
      r_coffee     <= w_coffee_next;
      r_change     <= w_change_next;
      r_change_vld <= w_change_vld_next;
      r_reject     <= w_reject_next;
    end
  end

  assign coffee     = r_coffee;
  assign change     = r_change;
  assign change_vld = r_change_vld;
  assign reject     = r_reject;
  assign credit     = r_credit;
  assign count      = r_count;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param (PRICE=20, AMT_W=5, CNT_W=3): the driver queues the
// expected pulse set per event, a negedge monitor pops and compares whenever a pulse appears.
module tb_vend_fsm_param;

  logic       clk;
  logic       rst;
  logic [4:0] amt;
  logic       amt_vld;
  logic       cancel;
  logic       coffee;
  logic [5:0] change;
  logic       change_vld;
  logic       reject;
  logic [5:0] credit;
  logic [2:0] count;

  vend_fsm_param #(.AMT_W(5), .PRICE(20), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .amt(amt), .amt_vld(amt_vld), .cancel(cancel),
    .coffee(coffee), .change(change), .change_vld(change_vld), .reject(reject),
    .credit(credit), .count(count)
  );

  typedef struct {
    logic       coffee;
    logic [5:0] change;
    logic       vld;
    logic       rej;
    logic [2:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   exp_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int expv);
    n_total++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, expv);
  endtask

  task automatic push(input logic cf, input int ch, input logic v, input logic rj, input int cn);
    exp_t e;
    e.coffee = cf;
    e.change = 6'(ch);
    e.vld    = v;
    e.rej    = rj;
    e.cnt    = 3'(cn);
    q.push_back(e);
  endtask

  // One clock: apply inputs, let the edge sample them, return at the following negedge.
  task automatic cyc(input logic v, input logic [4:0] a, input logic c);
    amt_vld = v;
    amt     = a;
    cancel  = c;
    @(negedge clk);
    amt_vld = 1'b0;
    amt     = '0;
    cancel  = 1'b0;
  endtask

  task automatic sale20();
    exp_count = (exp_count < 7) ? exp_count + 1 : 7;
    push(1'b1, 0, 1'b0, 1'b0, exp_count);
    cyc(1'b1, 5'd20, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (coffee || change_vld || reject) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: coffee=%0b change=%0d change_vld=%0b reject=%0b",
                 coffee, change, change_vld, reject);
      end else begin
        e = q.pop_front();
        chk("sb_coffee", int'(coffee), int'(e.coffee));
        chk("sb_change", int'(change), int'(e.change));
        chk("sb_change_vld", int'(change_vld), int'(e.vld));
        chk("sb_reject", int'(reject), int'(e.rej));
        chk("sb_count", int'(count), int'(e.cnt));
        $display("txn: coffee=%0b change=%0d change_vld=%0b reject=%0b count=%0d",
                 coffee, change, change_vld, reject, count);
      end
    end
  end

  initial begin
    rst = 1'b0; amt = 5'd0; amt_vld = 1'b0; cancel = 1'b0;
    // Reset overrides a coin and a cancel presented together with it.
    cyc(1'b1, 5'd20, 1'b1);
    cyc(1'b1, 5'd20, 1'b1);
    chk("rst_credit", int'(credit), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_coffee", int'(coffee), 0);
    chk("rst_change", int'(change), 0);
    chk("rst_change_vld", int'(change_vld), 0);
    chk("rst_reject", int'(reject), 0);
    rst = 1'b1;
    cyc(1'b0, 5'd0, 1'b0);

    // 5,5,10: exact price, no change.
    cyc(1'b1, 5'd5, 1'b0);   chk("credit_5", int'(credit), 5);
    cyc(1'b1, 5'd5, 1'b0);   chk("credit_10", int'(credit), 10);
    exp_count = 1;
    push(1'b1, 0, 1'b0, 1'b0, 1);
    cyc(1'b1, 5'd10, 1'b0);  chk("credit_after_sale1", int'(credit), 0);
    cyc(1'b0, 5'd0, 1'b0);   chk("coffee_one_cycle", int'(coffee), 0);

    // 15 then 10: change of 5.
    cyc(1'b1, 5'd15, 1'b0);  chk("credit_15", int'(credit), 15);
    exp_count = 2;
    push(1'b1, 5, 1'b1, 1'b0, 2);
    cyc(1'b1, 5'd10, 1'b0);  chk("credit_after_sale2", int'(credit), 0);
    cyc(1'b0, 5'd0, 1'b0);

    // Cancel with a completing coin refunds 20 and does not sell.
    cyc(1'b1, 5'd10, 1'b0);  chk("credit_10b", int'(credit), 10);
    push(1'b0, 20, 1'b1, 1'b0, 2);
    cyc(1'b1, 5'd10, 1'b1);  chk("credit_after_refund", int'(credit), 0);
    chk("count_after_refund", int'(count), 2);
    cyc(1'b0, 5'd0, 1'b0);

    // Coin during DISPENSE is rejected next cycle and not credited.
    exp_count = 3;
    push(1'b1, 0, 1'b0, 1'b0, 3);
    cyc(1'b1, 5'd20, 1'b0);
    push(1'b0, 0, 1'b0, 1'b1, 3);
    cyc(1'b1, 5'd5, 1'b0);   chk("credit_not_rejected_coin", int'(credit), 0);
    cyc(1'b0, 5'd0, 1'b0);   chk("reject_one_cycle", int'(reject), 0);

    // Cancel in IDLE and a zero-amount strobe do nothing.
    cyc(1'b0, 5'd0, 1'b1);   chk("idle_cancel_credit", int'(credit), 0);
    cyc(1'b1, 5'd0, 1'b0);   chk("zero_coin_credit", int'(credit), 0);
    cyc(1'b0, 5'd0, 1'b0);

    // Overpay boundaries: single 25 gives 5, 19+31=50 gives 30.
    exp_count = 4;
    push(1'b1, 5, 1'b1, 1'b0, 4);
    cyc(1'b1, 5'd25, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    cyc(1'b1, 5'd19, 1'b0);  chk("credit_19", int'(credit), 19);
    exp_count = 5;
    push(1'b1, 30, 1'b1, 1'b0, 5);
    cyc(1'b1, 5'd31, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);

    // Plain cancel in COLLECT refunds the held credit.
    cyc(1'b1, 5'd7, 1'b0);   chk("credit_7", int'(credit), 7);
    push(1'b0, 7, 1'b1, 1'b0, 5);
    cyc(1'b0, 5'd0, 1'b1);   chk("credit_after_cancel", int'(credit), 0);
    cyc(1'b0, 5'd0, 1'b0);

    // Saturation: five more sales push the counter past 7.
    for (int i = 0; i < 5; i++) sale20();
    chk("count_saturated", int'(count), 7);

    // Reset mid-COLLECT discards credit with no refund pulse.
    cyc(1'b1, 5'd10, 1'b0);  chk("credit_10c", int'(credit), 10);
    rst = 1'b0;
    cyc(1'b1, 5'd15, 1'b1);
    chk("midrst_credit", int'(credit), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_change_vld", int'(change_vld), 0);
    chk("midrst_coffee", int'(coffee), 0);
    rst = 1'b1;
    exp_count = 0;
    cyc(1'b0, 5'd0, 1'b0);
    sale20();
    chk("count_after_reset_sale", int'(count), 1);

    cyc(1'b0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0);
    chk("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised coin-accumulating vending controller. Successor to the fixed-price 5/10/15/20 coffee FSM: price, coin width and sales-counter width are parameters, and the block adds change return, a cancel/refund path and a coin-reject indication. It sits between the coin-acceptor front end, which delivers one strobed amount per coin, and the dispenser/change-hopper drivers. The sales counter feeds the service display.

## Interface
Parameters:
- AMT_W, 5, width of a coin amount in currency units.
- PRICE, 20, product price in currency units. Legal range is 1 to 2^AMT_W-1.
- CNT_W, 3, width of the sales counter.

Ports:
- clk  in  1  single clock. All state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low. Sampled only on the rising edge of clk.
- amt  in  AMT_W  coin value. Meaningful only while amt_vld=1.
- amt_vld  in  1  one-cycle coin strobe. A value of amt=0 with amt_vld=1 is ignored.
- cancel  in  1  level, sampled every edge. Requests a refund of the held credit.
- coffee  out  1  dispense pulse, exactly one cycle per sale.
- change  out  AMT_W+1  change or refund value. Valid only while change_vld=1, 0 otherwise.
- change_vld  out  1  one-cycle pulse. Asserted with coffee on a sale when change is nonzero, and on every refund.
- reject  out  1  one-cycle pulse. Indicates that a coin was strobed while the block could not accept it.
- credit  out  AMT_W+1  currently held credit.
- count  out  CNT_W  number of completed sales.

## Operation
- States: IDLE, COLLECT, DISPENSE, REFUND.
- The internal credit register is AMT_W+1 bits wide. Because PRICE-1+(2^AMT_W-1) < 2^(AMT_W+1), credit never overflows.
- In IDLE or COLLECT, on a valid coin (amt_vld=1, amt≠0): sum = credit+amt.
  - If sum ≥ PRICE: go to DISPENSE. Register coffee=1, change=sum-PRICE, change_vld=(sum≠PRICE), and clear credit to 0.
  - Otherwise: credit=sum, go to COLLECT.
- In COLLECT, with cancel=1: go to REFUND. Register change=credit+(valid coin amt, if one arrives the same cycle), change_vld=1, credit=0. Cancel overrides a completing coin: the block refunds and does not dispense.
- cancel in IDLE is ignored; no pulse is generated.
- DISPENSE and REFUND each last one cycle, then the block returns to IDLE unconditionally. At that exit edge coffee, change_vld and change all return to 0.
- A valid coin strobed in DISPENSE or REFUND is not credited. reject=1 is asserted in the following cycle.
- count increments by 1 on entry to DISPENSE and saturates at 2^CNT_W-1. It is never cleared except by reset.
- Unreachable state encodings go to IDLE, with the outputs taking their reset values.
- Reset (rst=0 at an edge): state=IDLE, credit=0, count=0, coffee=0, change=0, change_vld=0, reject=0.
  - Reset overrides any coin or cancel in the same cycle.
  - If reset occurs mid-COLLECT, the held credit is discarded with no refund pulse.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Coin-to-credit latency: 1 cycle. credit reflects a coin in the cycle after its strobe.
- Sale latency: the completing coin is sampled at edge N. coffee, change and change_vld are high during cycle N to N+1, and the block is back in IDLE from edge N+1.
- Back-to-back sales: a coin strobed in the DISPENSE cycle is rejected, so the next sale needs a coin at edge N+2 or later.
- reject asserts in the cycle after the offending strobe and lasts exactly one cycle.
- count updates at the same edge that raises coffee.

## Test plan
- PRICE=20: apply reset, then 5,5,10 on consecutive strobes. Expect credit 5→10, then coffee=1 for one cycle, change_vld=0, count=1, and a return to IDLE.
- PRICE=20: strobe 15, then 10. Expect coffee=1, change=5, change_vld=1 in the same cycle, and credit=0 afterwards.
- PRICE=20: strobe 10, then cancel=1 together with coin 10. Expect coffee=0, change=20, change_vld=1, count unchanged, state IDLE.
- A coin strobed in the DISPENSE cycle produces reject=1 one cycle later and is not credited. cancel asserted in IDLE produces no outputs.
- CNT_W=3: perform 9 sales. Expect count to saturate at 7. Then assert rst=0 mid-COLLECT with credit=10. Expect all outputs and credit to read 0 at the next edge, with no change_vld pulse.
